pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Central pipeline sequencer. Converts hazard-unit stall requests, ID-stage redirect/flush requests and instruction/data memory wait signals into per-stage write enables, flushes and bubble controls for the 5-stage core.
- Owns the multi-cycle stall countdown and the global freeze on data-memory wait.
- Maintains saturating performance counters.

Parameters:
- CNT_W, 8, width of stall length input and internal countdown
- PERF_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset; one clock; all state cleared while low
- stall_req  in  1  hazard unit requests an ID stall this cycle
- stall_len  in  CNT_W  requested stall length in cycles; 0 means no stall
- flush_req  in  1  ID-stage redirect (mispredict or jump); discard IF/ID contents
- imem_busy  in  1  instruction fetch not returning valid data this cycle
- dmem_busy  in  1  MEM-stage data access not complete; freeze whole pipeline
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  zero all control signals entering ID/EX
- idex_we  out  1  ID/EX write enable
- exmem_we  out  1  EX/MEM write enable
- memwb_bubble  out  1  zero control signals entering MEM/WB
- stalled  out  1  FSM in STALL state (debug/visibility)
- perf_stall  out  PERF_W  cycles with hazard stall active
- perf_freeze  out  PERF_W  cycles frozen by dmem_busy
- perf_flush  out  PERF_W  number of accepted flushes

Behaviour:
- FSM has two states: IDLE and STALL. Countdown register cnt (CNT_W bits).
- Reset (rst low): state=IDLE, cnt=0, all perf counters=0.
  - Outputs forced while reset is low: pc_we=0, ifid_we=0, idex_we=0, exmem_we=0, idex_bubble=1, memwb_bubble=1, ifid_flush=0, stalled=0.
  - Reset mid-stall abandons the countdown; the first cycle after release is IDLE.
- Outputs are combinational from state and inputs. Default when nothing is active: all *_we=1; flush and bubble signals 0.
- Per-cycle priority, highest first:
  1. dmem_busy=1 (freeze):
     - pc_we=0, ifid_we=0, idex_we=0, exmem_we=0, memwb_bubble=1.
     - ifid_flush=0, idex_bubble=0.
     - state and cnt hold; stall_req and flush_req are ignored (the hazard unit re-presents them).
     - perf_freeze+1.
  2. Hazard stall active, i.e. state==STALL, or state==IDLE with stall_req=1 and stall_len!=0:
     - pc_we=0, ifid_we=0, idex_bubble=1; downstream enables stay 1.
     - flush_req ignored: a branch in ID cannot resolve while its operands are pending.
     - perf_stall+1.
     - Entry from IDLE: if stall_len==1, remain IDLE. Otherwise go to STALL with cnt=stall_len-1.
     - In STALL: if cnt==1, go to IDLE; else cnt-1.
     - Total stalled cycles equals stall_len exactly, excluding freeze cycles.
     - stall_req/stall_len are ignored while in STALL.
  3. flush_req=1:
     - ifid_flush=1, pc_we=1, ifid_we=1.
     - perf_flush+1.
     - Also wins over a simultaneous imem_busy: the redirect still updates PC.
  4. imem_busy=1:
     - pc_we=0, ifid_flush=1 (NOP enters IF/ID); ID/EX and later advance normally.
- stall_req=1 with stall_len=0 is treated as no stall.
- stalled = (state==STALL).
- Perf counters saturate at all-ones with no wrap. Each increments at most once per cycle.

Test Plan:
- Reset release, then stall_req=1 with stall_len=2 for one cycle → pc_we=0 and idex_bubble=1 for exactly 2 cycles, stalled=1 only in the 2nd cycle, then pc_we=1; perf_stall=2.
- stall_len=2 with dmem_busy=1 during the 2nd stall cycle → freeze cycle inserted (exmem_we=0, memwb_bubble=1), stall resumes afterwards for a total of 2 hazard cycles over 3 clocks; perf_freeze=1.
- flush_req=1 in the same cycle as stall entry (stall_len=1) → no ifid_flush; flush_req=1 in the next cycle → ifid_flush=1, pc_we=1; perf_flush=1.
- flush_req=1 with imem_busy=1 → pc_we=1, ifid_flush=1. imem_busy alone → pc_we=0, ifid_flush=1, idex_we=1.
- stall_len=5, rst driven low in the 3rd stall cycle → outputs immediately go to reset values; after release the FSM is IDLE, pc_we=1, perf counters=0.
- PERF_W=4 with 20 consecutive dmem_busy cycles → perf_freeze stops at 15; stall_req=1 with stall_len=0 → no stall.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the core datapath:
// hazard/memory requests in, per-stage enables and perf counters out.
interface pipeline_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int PERF_W = 32
);
  logic              stall_req;
  logic [CNT_W-1:0]  stall_len;
  logic              flush_req;
  logic              imem_busy;
  logic              dmem_busy;

  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_we;
  logic              exmem_we;
  logic              memwb_bubble;
  logic              stalled;
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_freeze;
  logic [PERF_W-1:0] perf_flush;

  modport master (
    output stall_req, stall_len, flush_req, imem_busy, dmem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we,
           memwb_bubble, stalled, perf_stall, perf_freeze, perf_flush
  );

  modport slave (
    input  stall_req, stall_len, flush_req, imem_busy, dmem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we,
           memwb_bubble, stalled, perf_stall, perf_freeze, perf_flush
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline sequencer: turns stall, flush and memory-wait
// requests into per-stage enables/bubbles, and keeps saturating perf counters.
module pipeline_ctrl #(
  parameter int CNT_W  = 8,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic [PERF_W-1:0] r_perfStall;
  logic [PERF_W-1:0] r_perfFreeze;
  logic [PERF_W-1:0] r_perfFlush;

  logic w_hazard;
  logic w_incStall;
  logic w_incFreeze;
  logic w_incFlush;
  logic w_pcWe;
  logic w_ifidWe;
  logic w_ifidFlush;
  logic w_idexBubble;
  logic w_idexWe;
  logic w_exmemWe;
  logic w_memwbBubble;

  // A zero-length request is no stall at all; in STALL new requests are ignored.
  assign w_hazard = (r_state == STALL) ||
                    (bus.stall_req && (bus.stall_len != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_pcWe        = 1'b1;
    w_ifidWe      = 1'b1;
    w_ifidFlush   = 1'b0;
    w_idexBubble  = 1'b0;
    w_idexWe      = 1'b1;
    w_exmemWe     = 1'b1;
    w_memwbBubble = 1'b0;
    w_incStall    = 1'b0;
    w_incFreeze   = 1'b0;
    w_incFlush    = 1'b0;

    if (!rst) begin
      w_pcWe        = 1'b0;
      w_ifidWe      = 1'b0;
      w_idexWe      = 1'b0;
      w_exmemWe     = 1'b0;
      w_idexBubble  = 1'b1;
      w_memwbBubble = 1'b1;
    end else if (bus.dmem_busy) begin
      w_pcWe        = 1'b0;
      w_ifidWe      = 1'b0;
      w_idexWe      = 1'b0;
      w_exmemWe     = 1'b0;
      w_memwbBubble = 1'b1;
      w_incFreeze   = 1'b1;
    end else if (w_hazard) begin
      w_pcWe       = 1'b0;
      w_ifidWe     = 1'b0;
      w_idexBubble = 1'b1;
      w_incStall   = 1'b1;
      // The entry cycle counts as the first stall cycle, so cnt holds the remainder.
      if (r_state == IDLE) begin
        if (bus.stall_len != CNT_W'(1)) begin
          w_stateNext = STALL;
          w_cntNext   = bus.stall_len - CNT_W'(1);
        end
      end else if (r_cnt == CNT_W'(1)) begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end else begin
        w_cntNext = r_cnt - CNT_W'(1);
      end
    end else if (bus.flush_req) begin
      w_ifidFlush = 1'b1;
      w_incFlush  = 1'b1;
    end else if (bus.imem_busy) begin
      w_pcWe      = 1'b0;
      w_ifidFlush = 1'b1;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfStall  <= '0;
      r_perfFreeze <= '0;
      r_perfFlush  <= '0;
    end else begin
      if (w_incStall && (r_perfStall != '1))
        r_perfStall <= r_perfStall + PERF_W'(1);
      if (w_incFreeze && (r_perfFreeze != '1))
        r_perfFreeze <= r_perfFreeze + PERF_W'(1);
      if (w_incFlush && (r_perfFlush != '1))
        r_perfFlush <= r_perfFlush + PERF_W'(1);
    end
  end

  assign bus.pc_we        = w_pcWe;
  assign bus.ifid_we      = w_ifidWe;
  assign bus.ifid_flush   = w_ifidFlush;
  assign bus.idex_bubble  = w_idexBubble;
  assign bus.idex_we      = w_idexWe;
  assign bus.exmem_we     = w_exmemWe;
  assign bus.memwb_bubble = w_memwbBubble;
  assign bus.stalled      = rst && (r_state == STALL);
  assign bus.perf_stall   = r_perfStall;
  assign bus.perf_freeze  = r_perfFreeze;
  assign bus.perf_flush   = r_perfFlush;

endmodule
